// File: rtl/bwt_ctrl_if.sv
// Stream, drain and datapath-control bundle for the BWT sequencing controller.
interface bwt_ctrl_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       bwt_en;
    logic [9:0] bwt_adr;
    logic [7:0] bwt_char;
    logic [9:0] bwt_len;
    logic       bwt_done;
    logic [7:0] bwt_out;

    modport master (
        input  s_valid, s_data, s_last, m_ready, bwt_done, bwt_out,
        output s_ready, m_valid, m_data, m_last, bwt_en, bwt_adr, bwt_char, bwt_len
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready, bwt_done, bwt_out,
        input  s_ready, m_valid, m_data, m_last, bwt_en, bwt_adr, bwt_char, bwt_len
    );
endinterface

// File: rtl/bwt_ctrl.sv
// BWT sequencing controller: loads a string into the datapath, waits for the
// transform, then drains the result in descending address order.
//
// state      | meaning
// IDLE       | waiting for the first character of a string
// LOAD       | writing further characters into the datapath
// COMPUTE    | datapath transforming, timeout counter running
// DRAIN      | emitting bwt_out from address bwt_len-1 down to 0
module bwt_ctrl #(
    parameter int MAX_LEN = 1023,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    bwt_ctrl_if.master  bus,
    output logic        busy,
    output logic [1:0]  err
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [9:0]      LAST_IDX = 10'(MAX_LEN - 1);
    localparam logic [CW-1:0]   CYC_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [9:0]    count;
    logic [CW-1:0] cyc;
    logic          wr_pending;
    logic [9:0]    adr_q;
    logic [9:0]    len_q;
    logic [7:0]    char_q;

    logic          accepting;
    logic          draining;
    logic          s_hs;
    logic          ovf;
    logic          last_char;
    logic [9:0]    wr_idx;

    always_comb begin
        accepting = (state == ST_IDLE) || (state == ST_LOAD);
        draining  = (state == ST_DRAIN);
        s_hs      = accepting && bus.s_valid;
        wr_idx    = (state == ST_IDLE) ? 10'd0 : count;
        ovf       = !bus.s_last && (wr_idx == LAST_IDX);
        last_char = bus.s_last || ovf;
    end

    // Gated by rst so the combinational enables read as zero while reset is held.
    assign bus.s_ready  = accepting & ~rst;
    assign bus.bwt_en   = (accepting | wr_pending) & ~rst;
    assign bus.m_valid  = draining;
    assign bus.m_data   = draining ? bus.bwt_out : 8'd0;
    assign bus.m_last   = draining && (adr_q == 10'd0);
    assign bus.bwt_adr  = adr_q;
    assign bus.bwt_char = char_q;
    assign bus.bwt_len  = len_q;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= 10'd0;
            cyc        <= '0;
            wr_pending <= 1'b0;
            adr_q      <= 10'd0;
            len_q      <= 10'd0;
            char_q     <= 8'd0;
            err        <= 2'b00;
        end else begin
            wr_pending <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (s_hs) begin
                        adr_q  <= wr_idx;
                        char_q <= bus.s_data;
                        count  <= wr_idx + 10'd1;
                        if (state == ST_IDLE)
                            err <= {1'b0, ovf};
                        else if (ovf)
                            err[0] <= 1'b1;
                        if (last_char) begin
                            len_q      <= wr_idx + 10'd1;
                            wr_pending <= 1'b1;
                            cyc        <= '0;
                            state      <= ST_COMPUTE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (bus.bwt_done) begin
                        adr_q <= len_q - 10'd1;
                        state <= ST_DRAIN;
                    end else if (cyc == CYC_LAST) begin
                        err[1] <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_ready) begin
                        if (adr_q == 10'd0)
                            state <= ST_IDLE;
                        else
                            adr_q <= adr_q - 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bwt_ctrl.sv
// Bench for bwt_ctrl: two instances (default sizes, and MAX_LEN=4/TIMEOUT=8)
// with a memory stub standing in for the transform datapath.
module tb_bwt_ctrl;
    logic clk;
    logic rst;
    logic sel;
    logic s_valid, s_last, m_ready, bwt_done;
    logic [7:0] s_data;

    logic        busy_a, busy_b;
    logic [1:0]  err_a, err_b;

    logic        o_s_ready, o_m_valid, o_m_last, o_bwt_en, o_busy;
    logic [7:0]  o_m_data, o_bwt_char;
    logic [9:0]  o_bwt_adr, o_bwt_len;
    logic [1:0]  o_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] str_q[$];

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];

    bwt_ctrl_if ifa ();
    bwt_ctrl_if ifb ();

    bwt_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .err(err_a));
    bwt_ctrl #(.MAX_LEN(4), .TIMEOUT(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .err(err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifa.s_valid  = s_valid & ~sel;
    assign ifb.s_valid  = s_valid & sel;
    assign ifa.s_data   = s_data;
    assign ifb.s_data   = s_data;
    assign ifa.s_last   = s_last;
    assign ifb.s_last   = s_last;
    assign ifa.m_ready  = m_ready & ~sel;
    assign ifb.m_ready  = m_ready & sel;
    assign ifa.bwt_done = bwt_done & ~sel;
    assign ifb.bwt_done = bwt_done & sel;

    // Datapath stub: captures writes, returns a known function of stored char and address.
    always @(posedge clk) begin
        if (ifa.bwt_en) mem_a[ifa.bwt_adr] <= ifa.bwt_char;
        if (ifb.bwt_en) mem_b[ifb.bwt_adr] <= ifb.bwt_char;
    end
    assign ifa.bwt_out = mem_a[ifa.bwt_adr] ^ ifa.bwt_adr[7:0] ^ 8'h5A;
    assign ifb.bwt_out = mem_b[ifb.bwt_adr] ^ ifb.bwt_adr[7:0] ^ 8'h5A;

    assign o_s_ready  = sel ? ifb.s_ready  : ifa.s_ready;
    assign o_m_valid  = sel ? ifb.m_valid  : ifa.m_valid;
    assign o_m_data   = sel ? ifb.m_data   : ifa.m_data;
    assign o_m_last   = sel ? ifb.m_last   : ifa.m_last;
    assign o_bwt_en   = sel ? ifb.bwt_en   : ifa.bwt_en;
    assign o_bwt_adr  = sel ? ifb.bwt_adr  : ifa.bwt_adr;
    assign o_bwt_char = sel ? ifb.bwt_char : ifa.bwt_char;
    assign o_bwt_len  = sel ? ifb.bwt_len  : ifa.bwt_len;
    assign o_busy     = sel ? busy_b : busy_a;
    assign o_err      = sel ? err_b  : err_a;

    task automatic fill_rand(input int len);
        str_q.delete();
        for (int i = 0; i < len; i++) str_q.push_back(8'($urandom));
    endtask

    task automatic push_char(input logic [7:0] c, input logic l, input int exp_adr, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({o_s_ready, o_bwt_adr} !== {1'b1, 10'(exp_adr - 1)}) begin
                errors++;
                $display("FAIL gap_hold got rdy=%0b adr=%0d exp rdy=1 adr=%0d", o_s_ready, o_bwt_adr, exp_adr - 1);
            end
        end
        s_valid = 1'b1;
        s_data  = c;
        s_last  = l;
        while (!o_s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait got s_ready=%0b exp 1", o_s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if ({o_bwt_en, o_bwt_adr, o_bwt_char} !== {1'b1, 10'(exp_adr), c}) begin
            errors++;
            $display("FAIL write got en=%0b adr=%0d char=%0h exp en=1 adr=%0d char=%0h",
                     o_bwt_en, o_bwt_adr, o_bwt_char, exp_adr, c);
        end
    endtask

    task automatic drain_string(input int stall_at, input bit rnd_stall);
        int idx, n, stall_left, len;
        bit stalled;
        logic [7:0] exp_d;
        len = str_q.size();
        idx = len - 1;
        n = 0;
        stall_left = 0;
        stalled = 1'b0;
        while (idx >= 0 && n < 4 * len + 50) begin
            n++;
            exp_d = str_q[idx] ^ 8'(idx) ^ 8'h5A;
            checks++;
            if ({o_m_valid, o_m_data, o_bwt_adr, o_m_last} !== {1'b1, exp_d, 10'(idx), (idx == 0)}) begin
                errors++;
                $display("FAIL drain got v=%0b d=%0h adr=%0d last=%0b exp v=1 d=%0h adr=%0d last=%0b",
                         o_m_valid, o_m_data, o_bwt_adr, o_m_last, exp_d, idx, (idx == 0));
            end
            if (idx == stall_at && !stalled) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (m_ready) idx--;
        end
        m_ready = 1'b0;
        checks++;
        if ({o_m_valid, o_busy, o_s_ready} !== 3'b001) begin
            errors++;
            $display("FAIL drain_end got v=%0b busy=%0b rdy=%0b exp v=0 busy=0 rdy=1", o_m_valid, o_busy, o_s_ready);
        end
    endtask

    task automatic run_string(input bit gaps, input int done_dly, input int stall_at, input bit rnd_stall);
        int len;
        len = str_q.size();
        for (int i = 0; i < len; i++)
            push_char(str_q[i], (i == len - 1), i, gaps && (i > 0));
        checks++;
        if ({o_bwt_len, o_s_ready, o_busy} !== {10'(len), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL compute_entry got len=%0d rdy=%0b busy=%0b exp len=%0d rdy=0 busy=1", o_bwt_len, o_s_ready, o_busy, len);
        end
        @(negedge clk);
        checks++;
        if (o_bwt_en !== 1'b0) begin
            errors++;
            $display("FAIL compute_en got %0b exp 0", o_bwt_en);
        end
        for (int i = 1; i < done_dly; i++) @(negedge clk);
        checks++;
        if ({o_m_valid, o_bwt_len} !== {1'b0, 10'(len)}) begin
            errors++;
            $display("FAIL pre_done got v=%0b len=%0d exp v=0 len=%0d", o_m_valid, o_bwt_len, len);
        end
        bwt_done = 1'b1;
        @(negedge clk);
        bwt_done = 1'b0;
        drain_string(stall_at, rnd_stall);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            checks++;
            if ({o_s_ready, o_m_valid, o_m_last, o_m_data, o_bwt_en, o_bwt_adr, o_bwt_char, o_bwt_len, o_busy, o_err} !== 43'd0) begin
                errors++;
                $display("FAIL reset_vals dut=%0d rdy=%0b en=%0b busy=%0b err=%0b exp all zero", k, o_s_ready, o_bwt_en, o_busy, o_err);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_s_ready, o_busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got rdy=%0b busy=%0b exp rdy=1 busy=0", o_s_ready, o_busy);
        end
    endtask

    task automatic test_banana();
        sel = 1'b0;
        str_q = '{8'h62, 8'h61, 8'h6e, 8'h61, 8'h6e, 8'h61};
        run_string(1'b0, 20, -1, 1'b0);
    endtask

    task automatic test_gaps_stall();
        sel = 1'b0;
        fill_rand(4);
        run_string(1'b1, 5, 2, 1'b0);
    endtask

    task automatic test_single();
        sel = 1'b0;
        str_q = '{8'h78};
        run_string(1'b0, 4, -1, 1'b0);
        bwt_done = 1'b1;
        @(negedge clk);
        bwt_done = 1'b0;
        checks++;
        if ({o_m_valid, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_in_idle got v=%0b busy=%0b exp 0 0", o_m_valid, o_busy);
        end
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int r = 0; r < 6; r++) begin
            fill_rand($urandom_range(1, 12));
            run_string(1'($urandom_range(0, 1)), $urandom_range(1, 15), -1, 1'b1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] c[6];
        sel = 1'b1;
        for (int i = 0; i < 6; i++) c[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push_char(c[i], 1'b0, i, 1'b0);
        checks++;
        if ({o_err, o_bwt_len, o_s_ready, o_busy} !== {2'b01, 10'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow got err=%0b len=%0d rdy=%0b busy=%0b exp err=01 len=4 rdy=0 busy=1", o_err, o_bwt_len, o_s_ready, o_busy);
        end
        @(negedge clk);
        @(negedge clk);
        bwt_done = 1'b1;
        @(negedge clk);
        bwt_done = 1'b0;
        str_q = '{c[0], c[1], c[2], c[3]};
        drain_string(-1, 1'b0);
        checks++;
        if (o_err !== 2'b01) begin
            errors++;
            $display("FAIL err_sticky got %0b exp 01", o_err);
        end
        push_char(c[4], 1'b0, 0, 1'b0);
        checks++;
        if (o_err !== 2'b00) begin
            errors++;
            $display("FAIL err_clear got %0b exp 00", o_err);
        end
        push_char(c[5], 1'b0, 1, 1'b0);
        str_q = '{c[4], c[5], 8'h33};
        push_char(8'h33, 1'b1, 2, 1'b0);
        checks++;
        if ({o_bwt_len, o_err} !== {10'd3, 2'b00}) begin
            errors++;
            $display("FAIL second_str got len=%0d err=%0b exp len=3 err=00", o_bwt_len, o_err);
        end
        @(negedge clk);
        bwt_done = 1'b1;
        @(negedge clk);
        bwt_done = 1'b0;
        drain_string(-1, 1'b0);
    endtask

    task automatic test_timeout();
        sel = 1'b1;
        push_char(8'h41, 1'b0, 0, 1'b0);
        push_char(8'h42, 1'b1, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({o_busy, o_m_valid} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait cycle=%0d got busy=%0b v=%0b exp busy=1 v=0", i, o_busy, o_m_valid);
            end
            @(negedge clk);
        end
        checks++;
        if ({o_busy, o_err, o_m_valid, o_s_ready} !== {1'b0, 2'b10, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout got busy=%0b err=%0b v=%0b rdy=%0b exp busy=0 err=10 v=0 rdy=1", o_busy, o_err, o_m_valid, o_s_ready);
        end
        fill_rand(2);
        run_string(1'b0, 3, -1, 1'b0);
        checks++;
        if (o_err !== 2'b00) begin
            errors++;
            $display("FAIL timeout_clear got %0b exp 00", o_err);
        end
    endtask

    task automatic test_reset_abort();
        sel = 1'b0;
        push_char(8'h11, 1'b0, 0, 1'b0);
        push_char(8'h22, 1'b0, 1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_s_ready, o_m_valid, o_m_last, o_m_data, o_bwt_en, o_bwt_adr, o_bwt_char, o_bwt_len, o_busy, o_err} !== 43'd0) begin
            errors++;
            $display("FAIL reset_load adr=%0d busy=%0b en=%0b exp all zero", o_bwt_adr, o_busy, o_bwt_en);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_rand(3);
        run_string(1'b0, 2, -1, 1'b0);

        fill_rand(5);
        for (int i = 0; i < 5; i++) push_char(str_q[i], (i == 4), i, 1'b0);
        @(negedge clk);
        bwt_done = 1'b1;
        @(negedge clk);
        bwt_done = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({o_m_valid, o_bwt_adr, o_m_data} !== {1'b1, 10'd2, str_q[2] ^ 8'd2 ^ 8'h5A}) begin
            errors++;
            $display("FAIL third_out got v=%0b adr=%0d d=%0h exp v=1 adr=2 d=%0h", o_m_valid, o_bwt_adr, o_m_data, str_q[2] ^ 8'd2 ^ 8'h5A);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({o_s_ready, o_m_valid, o_m_last, o_m_data, o_bwt_en, o_bwt_adr, o_bwt_char, o_bwt_len, o_busy, o_err} !== 43'd0) begin
            errors++;
            $display("FAIL reset_drain v=%0b last=%0b adr=%0d busy=%0b exp all zero", o_m_valid, o_m_last, o_bwt_adr, o_busy);
        end
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_rand(4);
        run_string(1'b1, 6, 1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'd0;
        m_ready = 1'b0;
        bwt_done = 1'b0;
        test_reset();
        test_banana();
        test_gaps_stall();
        test_single();
        test_random();
        test_overflow();
        test_timeout();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bwt_ctrl.md
BWT_CTRL -- requirements
Module: bwt_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 1023: maximum string length in characters; must be at most 1023.
REQ-002 Parameter TIMEOUT, default 65535: maximum number of cycles spent waiting for bwt_done.
REQ-003 clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 rst, input, 1: asynchronous, active-high reset.
REQ-005 s_valid, input, 1: input character is valid.
REQ-006 s_data, input, 8: input character.
REQ-007 s_last, input, 1: marks the final character of the string.
REQ-008 s_ready, output, 1: controller accepts the input character.
REQ-009 m_valid, output, 1: output character is valid.
REQ-010 m_data, output, 8: transformed character.
REQ-011 m_last, output, 1: marks the final output character.
REQ-012 m_ready, input, 1: downstream accepts the output character.
REQ-013 bwt_en, output, 1: load enable to the datapath; 1 = write, 0 = compute/read.
REQ-014 bwt_adr, output, 10: datapath address.
REQ-015 bwt_char, output, 8: character written into the datapath.
REQ-016 bwt_len, output, 10: string length presented to the datapath.
REQ-017 bwt_done, input, 1: datapath transform complete.
REQ-018 bwt_out, input, 8: datapath output character at bwt_adr, combinational in the same cycle.
REQ-019 busy, output, 1: high in every state except IDLE.
REQ-020 err, output, 2: sticky error flags; bit0 = overflow, bit1 = timeout; cleared on the next accepted first character.

Function
REQ-021 The FSM shall have the states IDLE, LOAD, COMPUTE and DRAIN, with transitions only as defined below.
REQ-022 IDLE: s_ready=1 and bwt_en=1; an accepted character is written at address 0, the count is set to 1, and the FSM moves to LOAD (or to COMPUTE if s_last=1).
REQ-023 LOAD: s_ready=1 and bwt_en=1; each handshake (s_valid&s_ready) presents bwt_char=s_data and bwt_adr=count in that cycle, then count increments.
REQ-024 Write timing: bwt_adr and bwt_char are registered outputs that update on the handshake edge; bwt_en stays high for one further cycle after the final write so the datapath captures it.
REQ-025 Gaps with s_valid=0 shall not advance count or bwt_adr.
REQ-026 LOAD ends on a handshake with s_last=1: bwt_len is set to the count including that character, and the FSM enters COMPUTE.
REQ-027 Overflow: a handshake at count=MAX_LEN-1 with s_last=0 shall be treated as last, set err[0], and set bwt_len=MAX_LEN; later input waits in the next IDLE.
REQ-028 COMPUTE: s_ready=0 and bwt_en=0, and bwt_len is held stable; a cycle counter increments from 0.
REQ-029 When bwt_done=1 is sampled, the FSM shall load bwt_adr=bwt_len-1 and enter DRAIN, so m_valid rises exactly one cycle after bwt_done is sampled high.
REQ-030 Timeout: if the counter reaches TIMEOUT without bwt_done, the FSM shall set err[1], emit no output, and return to IDLE.
REQ-031 DRAIN: m_valid=1 and m_data=bwt_out; m_last=1 when bwt_adr=0.
REQ-032 In DRAIN, each m_valid&m_ready handshake decrements bwt_adr; m_valid=1 with m_ready=0 holds bwt_adr and m_data stable.
REQ-033 The handshake with m_last=1 shall return the FSM to IDLE; exactly bwt_len characters are emitted, in descending address order.
REQ-034 bwt_adr shall never wrap below 0 or exceed MAX_LEN-1.
REQ-035 A string of length 1 shall be legal: one write, then one output with m_last=1.
REQ-036 bwt_done=1 outside COMPUTE shall be ignored.

Reset
REQ-037 On rst=1 the state shall be IDLE and outputs shall be s_ready=0, m_valid=0, m_last=0, m_data=0, bwt_en=0, bwt_adr=0, bwt_char=0, bwt_len=0, busy=0, err=0, with counters cleared.
REQ-038 s_ready shall rise in the first cycle after rst deasserts.
REQ-039 Reset asserted mid-LOAD, mid-COMPUTE or mid-DRAIN shall abort immediately; a partial string is discarded and no m_last is produced.

Verification
REQ-040 Stream "banana" (6 bytes, s_last on 'a') -> addresses 0..5 written, bwt_len=6, bwt_en low in COMPUTE; with bwt_done stubbed after 20 cycles, m_data follows stub addresses 5,4,3,2,1,0 with m_last on the 6th output.
REQ-041 s_valid toggling every other cycle during a 4-character load, plus m_ready low for 3 cycles mid-drain -> no duplicated or skipped addresses, and m_data held stable while stalled.
REQ-042 MAX_LEN=4 and 6 characters sent without s_last -> err=01, bwt_len=4, 4 outputs; the remaining 2 characters begin a new string.
REQ-043 TIMEOUT=8 and bwt_done never asserted -> err=10 after 8 COMPUTE cycles, FSM returns to IDLE, no m_valid.
REQ-044 Single character 'x' with s_last -> one output at address 0, m_last=1, then IDLE.
REQ-045 rst pulsed on the 3rd DRAIN output -> all outputs at reset values in the same cycle, and the next string processes correctly.
